// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; mult/div results land W+1 cycles after issue, MTHI/MTLO land next cycle.
// Latency: W+1 cycles for mult/div with a one-cycle done pulse; 1 cycle for MTHI/MTLO. Backpressure: start is ignored while busy, so issue must stall on busy.
module mdu #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [2:0]            MDUOp,
    input  logic [WORD_WIDTH-1:0] inA,
    input  logic [WORD_WIDTH-1:0] inB,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] hi,
    output logic [WORD_WIDTH-1:0] lo
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;       // multiply: {partial product, remaining multiplier}
    logic [W-1:0]   a_q, a_d;           // multiplicand, or dividend shifting out / quotient shifting in
    logic [W-1:0]   b_q, b_d;           // divisor magnitude
    logic [W-1:0]   rem_q, rem_d;
    logic           div_q, div_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           done_q, done_d;

    logic           is_signed, is_md;
    logic [W-1:0]   mag_a, mag_b, mul_addend, quo, rmd;
    logic [W:0]     add_sum, shifted, diff;
    logic [2*W-1:0] prod;

    always_comb begin
        is_signed  = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
        is_md      = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                     (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        mag_a      = (is_signed && inA[W-1]) ? -inA : inA;
        mag_b      = (is_signed && inB[W-1]) ? -inB : inB;
        mul_addend = acc_q[0] ? a_q : {W{1'b0}};
        add_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
        shifted    = {rem_q, a_q[W-1]};
        diff       = shifted - {1'b0, b_q};
        prod       = neg_res_q ? -acc_q : acc_q;
        quo        = neg_res_q ? -a_q : a_q;
        // A zero divisor leaves the dividend magnitude in rem, so sign restore yields inA as issued.
        rmd        = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && is_md) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    a_d       = mag_a;
                    b_d       = mag_b;
                    acc_d     = {{W{1'b0}}, mag_b};
                    rem_d     = '0;
                    div_d     = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
                    neg_res_d = is_signed && (inA[W-1] ^ inB[W-1]);
                    neg_rem_d = is_signed && inA[W-1];
                    dz_d      = (inB == '0);
                end else if (start && MDUOp == OP_MTHI) begin
                    hi_d = inA;
                end else if (start && MDUOp == OP_MTLO) begin
                    lo_d = inA;
                end
            end
            RUN: begin
                if (div_q) begin
                    rem_d = diff[W] ? shifted[W-1:0] : diff[W-1:0];
                    a_d   = {a_q[W-2:0], ~diff[W]};
                end else begin
                    acc_d = {add_sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    hi_d = rmd;
                    lo_d = dz_q ? {W{1'b1}} : quo;
                end else begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
        // Squash beats both a new issue and a pending commit.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: scoreboard of expected {HI,LO} from a behavioural arithmetic model.
module tb_mdu;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert;
    int n_fail;
    logic [63:0] sb_q[$];

    mdu #(.WORD_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .MDUOp(MDUOp),
        .inA(inA), .inB(inB), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'b0;
        endcase
    endfunction

    task automatic single_op(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; MDUOp = op; inA = a;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 3'd0;
        @(negedge clk);
    endtask

    // inj_kind: 0 none, 1 MTHI while busy, 2 flush together with start, 3 flush only
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, input int inj_kind, input string tag);
        int k;
        bit got, flushed, seen_done;
        logic [31:0] hi0, lo0;
        logic [63:0] exp;
        @(negedge clk);
        hi0 = hi; lo0 = lo;
        if (inj_kind < 2) sb_q.push_back(model(op, a, b));
        start = 1'b1; MDUOp = op; inA = a; inB = b;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 3'd0;
        @(negedge clk);
        chk({tag, " busy_after_issue"}, {63'b0, busy}, 64'd1);
        k = 0; got = 0; flushed = 0;
        while (!got && !flushed && k < 60) begin
            if (k == inj_k) begin
                if (inj_kind == 1) begin
                    start = 1'b1; MDUOp = OP_MTHI; inA = 32'hDEAD_BEEF;
                end else if (inj_kind == 2) begin
                    start = 1'b1; MDUOp = OP_MTLO; inA = 32'h5555_5555; flush = 1'b1; flushed = 1;
                end else if (inj_kind == 3) begin
                    flush = 1'b1; flushed = 1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0; MDUOp = 3'd0;
            @(negedge clk);
            k++;
            got = done;
        end
        if (flushed) begin
            chk({tag, " busy_after_flush"}, {63'b0, busy}, 64'd0);
            chk({tag, " done_after_flush"}, {63'b0, done}, 64'd0);
            seen_done = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen_done = 1;
            end
            chk({tag, " no_done_later"}, {63'b0, seen_done}, 64'd0);
            chk({tag, " hi_kept"}, {32'b0, hi}, {32'b0, hi0});
            chk({tag, " lo_kept"}, {32'b0, lo}, {32'b0, lo0});
        end else begin
            chk({tag, " latency"}, 64'(k), 64'd33);
            exp = sb_q.pop_front();
            chk({tag, " hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
            chk({tag, " lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
            chk({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
            @(negedge clk);
            chk({tag, " done_one_cycle"}, {63'b0, done}, 64'd0);
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rstn = 1'b1; start = 1'b0; flush = 1'b0; MDUOp = 3'd0; inA = '0; inB = '0;
        #2 rstn = 1'b0;
        #1;
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset hi", {32'b0, hi}, 64'd0);
        chk("reset lo", {32'b0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        single_op(OP_MTLO, 32'h0000_00AA);
        chk("mtlo lo", {32'b0, lo}, 64'h0000_00AA);
        chk("mtlo busy", {63'b0, busy}, 64'd0);
        chk("mtlo done", {63'b0, done}, 64'd0);
        single_op(OP_MTHI, 32'h1234_5678);
        chk("mthi hi", {32'b0, hi}, 64'h1234_5678);
        chk("mthi lo_kept", {32'b0, lo}, 64'h0000_00AA);

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         -1, 0, "mult_neg3x7");
        chk("mult_neg3x7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, "multu_max");
        chk("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         -1, 0, "div_neg7by2");
        chk("div_neg7by2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIVU,  32'd100,       32'd7,         -1, 0, "divu_100by7");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 0, "div_ovf");
        chk("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(OP_DIVU,  32'h0000_1234, 32'd0,         -1, 0, "divu_by0");
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         -1, 0, "div_neg_by0");
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, -1, 0, "div_7byneg2");

        run_op(OP_MULT,  32'h1234_5678, 32'h9ABC_DEF0,  5, 1, "mult_mthi_busy");
        run_op(OP_DIV,   32'd1000,      32'd7,         20, 2, "div_flush20");
        run_op(OP_DIVU,  32'd999,       32'd10,        32, 3, "divu_flush_fix");

        for (int i = 0; i < 4; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(1, 4));
            run_op(rop, $urandom, $urandom, -1, 0, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; MDUOp = OP_MULTU; inA = 32'hFFFF_FFFF; inB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 3'd0;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midreset hi", {32'b0, hi}, 64'd0);
        chk("midreset lo", {32'b0, lo}, 64'd0);
        chk("midreset busy", {63'b0, busy}, 64'd0);
        chk("midreset done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("postreset mfhi", {32'b0, hi}, 64'd0);
        chk("postreset busy", {63'b0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
